fu_issue_arbiter: RTL and testbench
===================================

// Module: fu_issue_arbiter
// PURPOSE
//   Issue scheduler for the functional units. Each cycle it picks at most one
//   requester per FU from the reservation-station request vector, grants it,
//   and tracks per-FU busy time with occupancy counters. It drives the FU
//   ready vector that the rename/dispatch stage reads in place of a static
//   ready table. Round-robin arbitration per FU prevents starvation.
// PARAMETERS
//   N_REQ     8   number of requesters (RS entries); index width IDX_W = $clog2(N_REQ)
//   NUM_FU    3   number of functional units; FU index field is 2 bits wide
//   LAT_W     4   width of each busy counter
//   FU_LAT    {3,1,1}  issue interval per FU (packed LAT_W each, FU2..FU0); >=1
// PORTS
//   clk             in   1               clock, rising edge
//   rst             in   1               synchronous reset, active-high
//   flush           in   1               suppress all grants this cycle
//   req_valid       in   N_REQ           requester i wants to issue
//   req_fu          in   2*N_REQ         target FU index of requester i ([2i+1:2i])
//   grant           out  N_REQ           requester i granted this cycle
//   fu_issue        out  NUM_FU          FU k receives an instruction this cycle
//   fu_issue_idx    out  IDX_W*NUM_FU    winning requester index for FU k
//   fu_ready        out  NUM_FU          FU k free (busy counter == 0)
// BEHAVIOUR
//   - State: busy_cnt[k] (LAT_W bits), rr_ptr[k] (IDX_W bits) per FU.
//   - Reset (rst=1 at posedge): all busy_cnt=0, all rr_ptr=0. Therefore
//     fu_ready = all ones and no grants in the first cycle after reset until
//     requests arrive. rst has priority over every other input.
//   - fu_ready[k] = (busy_cnt[k]==0); registered-state derived, no comb path
//     from req inputs.
//   - Grant (combinational, zero-cycle): for each FU k with fu_ready[k]=1 and
//     flush=0, the winner is the first i with req_valid[i] && req_fu[i]==k,
//     searching i = rr_ptr[k], rr_ptr[k]+1, ... wrapping modulo N_REQ.
//     fu_issue[k]=1, fu_issue_idx[k]=winner, grant[winner]=1.
//     No match -> fu_issue[k]=0, fu_issue_idx[k]=0.
//   - A requester targets one FU, so grant has at most NUM_FU bits set and
//     never two FUs on one requester.
//   - req_fu >= NUM_FU: request ignored, never granted.
//   - On posedge with fu_issue[k]=1: busy_cnt[k] <= FU_LAT[k]-1;
//     rr_ptr[k] <= (winner+1) mod N_REQ.
//     Otherwise busy_cnt[k] decrements by 1 if nonzero (saturates at 0);
//     rr_ptr[k] unchanged.
//   - Effect: FU_LAT=1 -> FU is grantable every cycle (fully pipelined);
//     FU_LAT=3 -> grant at cycle t, next possible grant at t+3.
//   - flush=1: grant, fu_issue all 0; busy counters keep counting down
//     (in-flight ops finish); rr_ptr unchanged.
//   - Requesters must deassert or change req_valid after grant; a request held
//     high after grant is treated as a new request in the next cycle.
//   - rst asserted mid-operation: busy counters cleared regardless of value,
//     grant outputs for that cycle still computed from pre-reset state but
//     not registered.
// TESTING
//   1. Reset, no requests -> fu_ready=3'b111, grant=0, fu_issue=0.
//   2. req_valid=8'h01, req_fu[0]=2 -> grant=8'h01, fu_issue=3'b100, idx[2]=0;
//      fu_ready=3'b011 for 2 cycles, 3'b111 on 3rd cycle after grant.
//   3. req_valid=8'h05 both FU0 held 4 cycles -> grants 0,2,0,2 (round-robin).
//   4. Reqs 1->FU0, 3->FU1, 6->FU2 same cycle -> grant=8'h4A, fu_issue=3'b111.
//   5. flush=1 with req_valid=8'hFF -> grant=0; busy FU2 counter still
//      decrements.
//   6. req_fu=3 on requester 4 -> never granted; rst while FU2 busy ->
//      fu_ready=3'b111 next cycle.

Source files
------------

// File: rtl/fu_issue_arbiter_if.sv
// Issue-arbiter bus: reservation-station requests in, grants and FU status out.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the slave modport drives grants and fu_ready back to the master.
//
// Signals:
//   flush        suppress all grants this cycle
//   req_valid    per-requester issue request
//   req_fu       per-requester target FU index, 2 bits each ([2i+1:2i])
//   grant        per-requester grant
//   fu_issue     per-FU issue strobe
//   fu_issue_idx per-FU winning requester index (IDX_W each)
//   fu_ready     per-FU free flag (busy counter == 0)
interface fu_issue_arbiter_if #(
    parameter int N_REQ  = 8,
    parameter int NUM_FU = 3,
    parameter int IDX_W  = $clog2(N_REQ)
);
    logic                    flush;
    logic [N_REQ-1:0]        req_valid;
    logic [2*N_REQ-1:0]      req_fu;
    logic [N_REQ-1:0]        grant;
    logic [NUM_FU-1:0]       fu_issue;
    logic [IDX_W*NUM_FU-1:0] fu_issue_idx;
    logic [NUM_FU-1:0]       fu_ready;

    // Requester side (reservation stations / test driver).
    modport master (
        output flush, req_valid, req_fu,
        input  grant, fu_issue, fu_issue_idx, fu_ready
    );

    // Arbiter side.
    modport slave (
        input  flush, req_valid, req_fu,
        output grant, fu_issue, fu_issue_idx, fu_ready
    );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Per-FU round-robin issue arbiter with busy counters that gate FU readiness.
// Latency: grants are combinational (zero-cycle); counters/pointers update on the next clk edge.
// Backpressure: a busy FU (counter != 0) or flush withholds grants; requesters simply hold or re-present.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fu_issue_arbiter_if.slave: flush, req_valid, req_fu in; grant, fu_issue, fu_issue_idx, fu_ready out
module fu_issue_arbiter #(
    parameter int                      N_REQ  = 8,
    parameter int                      NUM_FU = 3,
    parameter int                      LAT_W  = 4,
    parameter logic [NUM_FU*LAT_W-1:0] FU_LAT = {4'd3, 4'd1, 4'd1},
    localparam int                     IDX_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    fu_issue_arbiter_if.slave    bus
);

    logic [LAT_W-1:0]  busy_cnt_q [NUM_FU];
    logic [LAT_W-1:0]  busy_cnt_d [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr_q   [NUM_FU];
    logic [IDX_W-1:0]  rr_ptr_d   [NUM_FU];

    logic [NUM_FU-1:0]       fu_ready;
    logic [NUM_FU-1:0]       fu_issue;
    logic [IDX_W-1:0]        win [NUM_FU];
    logic [N_REQ-1:0]        grant;
    logic [IDX_W*NUM_FU-1:0] fu_issue_idx;

    // Arbitration: readiness depends only on registered counters, so there is
    // no combinational path from req inputs to fu_ready.
    always_comb begin
        grant        = '0;
        fu_issue     = '0;
        fu_ready     = '0;
        fu_issue_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            win[k]      = '0;
            fu_ready[k] = (busy_cnt_q[k] == '0);
            if (fu_ready[k] && !bus.flush) begin
                // Scan starting at the round-robin pointer; the first hit wins.
                for (int j = 0; j < N_REQ; j++) begin
                    if (!fu_issue[k]
                        && bus.req_valid[(int'(rr_ptr_q[k]) + j) % N_REQ]
                        && (int'(bus.req_fu[2*((int'(rr_ptr_q[k]) + j) % N_REQ) +: 2]) == k)) begin
                        fu_issue[k] = 1'b1;
                        win[k]      = IDX_W'((int'(rr_ptr_q[k]) + j) % N_REQ);
                    end
                end
            end
            // A requester names exactly one FU, so these grant bits never collide.
            if (fu_issue[k]) begin
                grant[win[k]] = 1'b1;
            end
            fu_issue_idx[k*IDX_W +: IDX_W] = win[k];
        end
    end

    // Next state: an issue reloads the counter with interval-1 (so the FU is
    // free again exactly FU_LAT cycles after the grant) and moves the pointer
    // just past the winner; otherwise count down to zero and hold the pointer.
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            busy_cnt_d[k] = busy_cnt_q[k];
            rr_ptr_d[k]   = rr_ptr_q[k];
            if (fu_issue[k]) begin
                busy_cnt_d[k] = FU_LAT[k*LAT_W +: LAT_W] - 1'b1;
                rr_ptr_d[k]   = IDX_W'((int'(win[k]) + 1) % N_REQ);
            end else if (busy_cnt_q[k] != '0) begin
                busy_cnt_d[k] = busy_cnt_q[k] - 1'b1;
            end
        end
    end

    // Reset overrides everything; grants computed in a reset cycle are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_FU; k++) begin
                busy_cnt_q[k] <= '0;
                rr_ptr_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                busy_cnt_q[k] <= busy_cnt_d[k];
                rr_ptr_q[k]   <= rr_ptr_d[k];
            end
        end
    end

    assign bus.grant        = grant;
    assign bus.fu_issue     = fu_issue;
    assign bus.fu_issue_idx = fu_issue_idx;
    assign bus.fu_ready     = fu_ready;

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Self-checking bench for fu_issue_arbiter.
// Latency: one vector per clock; inputs driven #1 after posedge, outputs sampled on negedge.
// Backpressure: none; expectations queue in a scoreboard and are popped when outputs are sampled.
module tb_fu_issue_arbiter;

    typedef struct {
        string       name;
        logic        rst;
        logic        flush;
        logic [7:0]  rv;
        logic [15:0] rf;
        logic [7:0]  exp_grant;
        logic [2:0]  exp_issue;
        logic [8:0]  exp_idx;
        logic [2:0]  exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fu_issue_arbiter_if bus ();

    fu_issue_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t vecs[20];

    function automatic vec_t mk(input string nm, input logic r, input logic fl,
                                input logic [7:0] rv, input logic [15:0] rf,
                                input logic [7:0] g, input logic [2:0] fi,
                                input logic [8:0] idx, input logic [2:0] rdy);
        vec_t v;
        v.name = nm; v.rst = r; v.flush = fl; v.rv = rv; v.rf = rf;
        v.exp_grant = g; v.exp_issue = fi; v.exp_idx = idx; v.exp_rdy = rdy;
        return v;
    endfunction

    task automatic cmp(input string nm, input string field,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s got %h want %h", nm, field, got, want);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
        end else begin
            e = exp_q.pop_front();
            cmp(e.name, "grant",    32'(bus.grant),        32'(e.exp_grant));
            cmp(e.name, "fu_issue", 32'(bus.fu_issue),     32'(e.exp_issue));
            cmp(e.name, "idx",      32'(bus.fu_issue_idx), 32'(e.exp_idx));
            cmp(e.name, "fu_ready", 32'(bus.fu_ready),     32'(e.exp_rdy));
        end
    endtask

    task automatic drive(input vec_t v);
        @(posedge clk);
        #1;
        rst           = v.rst;
        bus.flush     = v.flush;
        bus.req_valid = v.rv;
        bus.req_fu    = v.rf;
        exp_q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    // idx packing: FU2 at [8:6], FU1 at [5:3], FU0 at [2:0].
    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_fu    = '0;
        repeat (2) @(posedge clk);

        vecs[0]  = mk("reset_idle",  0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b111);
        vecs[1]  = mk("fu2_grant",   0, 0, 8'h01, 16'h0002, 8'h01, 3'b100, 9'h000, 3'b111);
        vecs[2]  = mk("fu2_busy1",   0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b011);
        vecs[3]  = mk("fu2_busy2",   0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b011);
        vecs[4]  = mk("fu2_free",    0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b111);
        vecs[5]  = mk("rr0_a",       0, 0, 8'h05, 16'h0000, 8'h01, 3'b001, 9'h000, 3'b111);
        vecs[6]  = mk("rr0_b",       0, 0, 8'h05, 16'h0000, 8'h04, 3'b001, 9'h002, 3'b111);
        vecs[7]  = mk("rr0_c",       0, 0, 8'h05, 16'h0000, 8'h01, 3'b001, 9'h000, 3'b111);
        vecs[8]  = mk("rr0_d",       0, 0, 8'h05, 16'h0000, 8'h04, 3'b001, 9'h002, 3'b111);
        // req1->FU0 (rr0=3 wraps to 1), req3->FU1, req6->FU2.
        vecs[9]  = mk("three_fu",    0, 0, 8'h4A, 16'h2040, 8'h4A, 3'b111, 9'h199, 3'b111);
        vecs[10] = mk("flush_a",     0, 1, 8'hFF, 16'h2040, 8'h00, 3'b000, 9'h000, 3'b011);
        vecs[11] = mk("flush_b",     0, 1, 8'hFF, 16'h2040, 8'h00, 3'b000, 9'h000, 3'b011);
        vecs[12] = mk("flush_c",     0, 1, 8'hFF, 16'h2040, 8'h00, 3'b000, 9'h000, 3'b111);
        vecs[13] = mk("bad_fu_a",    0, 0, 8'h10, 16'h0300, 8'h00, 3'b000, 9'h000, 3'b111);
        vecs[14] = mk("bad_fu_b",    0, 0, 8'h10, 16'h0300, 8'h00, 3'b000, 9'h000, 3'b111);
        // rr2=7 after three_fu, so the scan wraps to requester 0.
        vecs[15] = mk("fu2_wrap",    0, 0, 8'h01, 16'h0002, 8'h01, 3'b100, 9'h000, 3'b111);
        vecs[16] = mk("rst_busy",    1, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b011);
        vecs[17] = mk("post_rst",    0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b111);
        // rr0 was 2 before reset; a grant to requester 0 shows the pointer cleared.
        vecs[18] = mk("rr_cleared",  0, 0, 8'h05, 16'h0000, 8'h01, 3'b001, 9'h000, 3'b111);
        vecs[19] = mk("idle_end",    0, 0, 8'h00, 16'h0000, 8'h00, 3'b000, 9'h000, 3'b111);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i]);
        end

        // Held FU2 request: regranted at t and t+3 only.
        drive(mk("hold_t0", 0, 0, 8'h01, 16'h0002, 8'h01, 3'b100, 9'h000, 3'b111));
        drive(mk("hold_t1", 0, 0, 8'h01, 16'h0002, 8'h00, 3'b000, 9'h000, 3'b011));
        drive(mk("hold_t2", 0, 0, 8'h01, 16'h0002, 8'h00, 3'b000, 9'h000, 3'b011));
        drive(mk("hold_t3", 0, 0, 8'h01, 16'h0002, 8'h01, 3'b100, 9'h000, 3'b111));

        // Busy FU2 with a held request, then reset: counter clears immediately.
        drive(mk("rst_hold",  1, 0, 8'h01, 16'h0002, 8'h00, 3'b000, 9'h000, 3'b011));
        drive(mk("rst_after", 0, 0, 8'h00, 16'h0002, 8'h00, 3'b000, 9'h000, 3'b111));

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
